// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state type, default sizes and lane helpers for the data memory
package data_mem_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_RD_LAT = 1;
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/data_memory_pipe_if.sv
// data_memory_pipe_if: request/response bus between the MEM stage and the data memory
interface data_memory_pipe_if
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic rsp_valid, rsp_err, init_busy;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: N-deep response shift stage, cleared asynchronously so reset drops in-flight responses
module mem_rsp_pipe #(
  parameter int W = 18,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stg [N];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N; i++) stg[i] <= '0;
    else begin
      stg[0] <= d;
      for (int i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  assign q = stg[N-1];
endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: self-initialising word RAM with byte-addressed requests, lane writes and RD_LAT-cycle responses
module data_memory_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic clk,
  input logic rst_n,
  data_memory_pipe_if.slave bus
);
  localparam int NL = lanes(DATA_W);
  localparam int LSB = addr_lsb(DATA_W);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [IW-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic acc, bad, wr;
  logic [DATA_W-1:0] rd, merged;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = (state == INIT && cnt == IW'(DEPTH - 1)) ? READY : state;
    cnt_nx = (state == INIT) ? cnt + 1'b1 : cnt;
  end
  assign bus.req_ready = state == READY;
  assign bus.init_busy = state == INIT;
  assign acc = bus.req_valid & bus.req_ready;
  assign idx = bus.req_addr >> LSB;
  // errors never wrap: any index bit beyond the array counts as out of range
  assign bad = (|(bus.req_addr & ADDR_W'((1 << LSB) - 1))) || ({1'b0, idx} >= (ADDR_W + 1)'(DEPTH));
  assign wr = acc & bus.req_we & ~bad;
  assign rd = mem[idx[IW-1:0]];
  always_comb begin
    merged = rd;
    for (int k = 0; k < NL; k++) if (bus.req_be[k]) merged[8*k +: 8] = bus.req_wdata[8*k +: 8];
  end
  always_ff @(posedge clk)
    if (state == INIT) mem[cnt] <= DATA_W'(cnt);
    else if (wr) mem[idx[IW-1:0]] <= merged;
  mem_rsp_pipe #(.W(DATA_W + 2), .N(RD_LAT)) u_rsp (
    .clk(clk),
    .rst_n(rst_n),
    .d({acc, acc & bad, (acc & ~bus.req_we & ~bad) ? rd : '0}),
    .q({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata})
  );
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed checks of two instances (RD_LAT 1 and 2) driven by the same request stream
module tb_data_memory_pipe;
  logic clk = 0, rst_n = 0, vld = 0, we = 0;
  logic [15:0] addr = '0, wdata = '0;
  logic [1:0] be = '0;
  logic [31:0] r1, r2;
  int tests = 0, fails = 0;
  data_memory_pipe_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
  data_memory_pipe_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
  always #5 clk = ~clk;
  assign b1.req_valid = vld;
  assign b1.req_we = we;
  assign b1.req_addr = addr;
  assign b1.req_wdata = wdata;
  assign b1.req_be = be;
  assign b2.req_valid = vld;
  assign b2.req_we = we;
  assign b2.req_addr = addr;
  assign b2.req_wdata = wdata;
  assign b2.req_be = be;
  assign r1 = {14'd0, b1.rsp_valid, b1.rsp_err, b1.rsp_rdata};
  assign r2 = {14'd0, b2.rsp_valid, b2.rsp_err, b2.rsp_rdata};
  data_memory_pipe #(.DATA_W(16), .DEPTH(64), .ADDR_W(16), .RD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  data_memory_pipe #(.DATA_W(16), .DEPTH(64), .ADDR_W(16), .RD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  function automatic logic [31:0] rsp(input logic v, input logic e, input logic [15:0] d);
    return {14'd0, v, e, d};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    vld = 1; we = w; addr = a; wdata = d; be = b;
  endtask
  task automatic idle();
    vld = 0; we = 0;
  endtask
  task automatic op(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                    input logic [1:0] b, input logic e, input logic [15:0] x);
    drive(w, a, d, b);
    @(negedge clk);
    idle();
    chk({tag, "/lat1"}, r1, rsp(1'b1, e, x));
    chk({tag, "/lat2_early"}, r2, rsp(1'b0, 1'b0, 16'h0));
    @(negedge clk);
    chk({tag, "/lat2"}, r2, rsp(1'b1, e, x));
    chk({tag, "/lat1_pulse"}, r1, rsp(1'b0, 1'b0, 16'h0));
  endtask
  task automatic wait_init(input string tag);
    int n;
    logic stale, rdy;
    n = 0; stale = 0; rdy = 0;
    while (b1.init_busy && n < 200) begin
      rdy |= b1.req_ready | b2.req_ready;
      @(negedge clk);
      n++;
      stale |= b1.rsp_valid | b2.rsp_valid;
    end
    chk({tag, "/busy_cycles"}, n, 64);
    chk({tag, "/ready_during_init"}, {31'd0, rdy}, 0);
    chk({tag, "/stale_rsp"}, {31'd0, stale}, 0);
    chk({tag, "/ready_after"}, {28'd0, b1.init_busy, b1.req_ready, b2.init_busy, b2.req_ready}, 4'b0101);
  endtask
  initial begin
    #1;
    chk("rst_rsp1", r1, 0);
    chk("rst_rsp2", r2, 0);
    chk("rst_flags", {28'd0, b1.init_busy, b1.req_ready, b2.init_busy, b2.req_ready}, 4'b1010);
    @(negedge clk);
    rst_n = 1;
    wait_init("init1");
    op("rd_0a", 0, 16'h000A, 16'h0, 2'b00, 0, 16'h0005);
    op("wr_beef", 1, 16'h0010, 16'hBEEF, 2'b11, 0, 16'h0);
    op("rd_beef", 0, 16'h0010, 16'h0, 2'b00, 0, 16'hBEEF);
    op("wr_hi", 1, 16'h0010, 16'h1234, 2'b10, 0, 16'h0);
    op("rd_12ef", 0, 16'h0010, 16'h0, 2'b00, 0, 16'h12EF);
    op("rd_mis", 0, 16'h0011, 16'h0, 2'b00, 1, 16'h0);
    op("wr_oor", 1, 16'h0080, 16'hFFFF, 2'b11, 1, 16'h0);
    op("rd_00", 0, 16'h0000, 16'h0, 2'b00, 0, 16'h0000);
    op("wr_be0", 1, 16'h0014, 16'hAAAA, 2'b00, 0, 16'h0);
    op("rd_be0", 0, 16'h0014, 16'h0, 2'b00, 0, 16'h000A);
    op("rd_7e", 0, 16'h007E, 16'h0, 2'b00, 0, 16'h003F);
    drive(0, 16'h0002, 16'h0, 2'b00);
    @(negedge clk);
    chk("str_c1_l1", r1, rsp(1, 0, 16'h0001));
    chk("str_c1_l2", r2, rsp(0, 0, 16'h0));
    drive(0, 16'h0004, 16'h0, 2'b00);
    @(negedge clk);
    chk("str_c2_l1", r1, rsp(1, 0, 16'h0002));
    chk("str_c2_l2", r2, rsp(1, 0, 16'h0001));
    drive(0, 16'h0006, 16'h0, 2'b00);
    @(negedge clk);
    idle();
    chk("str_c3_l1", r1, rsp(1, 0, 16'h0003));
    chk("str_c3_l2", r2, rsp(1, 0, 16'h0002));
    @(negedge clk);
    chk("str_c4_l1", r1, rsp(0, 0, 16'h0));
    chk("str_c4_l2", r2, rsp(1, 0, 16'h0003));
    @(negedge clk);
    chk("str_c5_l2", r2, rsp(0, 0, 16'h0));
    drive(1, 16'h0020, 16'h5A5A, 2'b11);
    @(negedge clk);
    chk("b2b_wr_l1", r1, rsp(1, 0, 16'h0));
    drive(0, 16'h0020, 16'h0, 2'b00);
    @(negedge clk);
    idle();
    chk("b2b_rd_l1", r1, rsp(1, 0, 16'h5A5A));
    chk("b2b_wr_l2", r2, rsp(1, 0, 16'h0));
    @(negedge clk);
    chk("b2b_rd_l2", r2, rsp(1, 0, 16'h5A5A));
    rst_n = 0;
    #1;
    chk("rst2_flags", {30'd0, b1.init_busy, b1.req_ready}, 2'b10);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("init20_busy", {31'd0, b1.init_busy}, 1);
    rst_n = 0;
    #1;
    chk("rst3_flags", {28'd0, b1.init_busy, b1.req_ready, b2.init_busy, b2.req_ready}, 4'b1010);
    @(negedge clk);
    rst_n = 1;
    wait_init("init2");
    op("reinit_rd", 0, 16'h0020, 16'h0, 2'b00, 0, 16'h0010);
    drive(0, 16'h0002, 16'h0, 2'b00);
    @(negedge clk);
    drive(0, 16'h0004, 16'h0, 2'b00);
    @(posedge clk);
    #1;
    chk("inflight_pre_l2", r2, rsp(1, 0, 16'h0001));
    rst_n = 0;
    #1;
    chk("inflight_rst_l1", r1, 0);
    chk("inflight_rst_l2", r2, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    wait_init("init3");
    op("final_7e", 0, 16'h007E, 16'h0, 2'b00, 0, 16'h003F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
